matmul_sequencer: RTL and testbench

Sequencing controller for the N×N matrix-multiply datapath on the demo board. It loads both operand matrices as a serial element stream (switch value plus key strobe), then time-multiplexes one multiply-accumulate unit over all N³ products and stores the truncated results in a readable result bank. Result reads feed the 7-segment display path. A start/busy/done handshake lets the front-panel logic sequence repeated computations.

---
 rtl/matmul_sequencer.sv | 166 ++++++++++++++++
 tb/tb_matmul_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads two NxN operand matrices as a serial element stream,
// then time-multiplexes a single multiply-accumulate over all N^3 products and
// stores the truncated results in a combinationally readable bank.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_LOAD | accepting operand elements (A row-major, then B row-major)
// S_WAIT | operands held; waiting for start or reload
// S_CALC | one MAC per cycle over t = 0..N^3-1
module matmul_sequencer #(
    parameter int  WIDTH = 8,
    parameter int  N     = 2,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             start,
    input  logic             reload,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic             ovf,
    input  logic [IW-1:0]    rd_row,
    input  logic [IW-1:0]    rd_col,
    output logic [WIDTH-1:0] rd_data
);

    localparam int NN  = N * N;
    localparam int NNN = NN * N;
    localparam int EW  = $clog2(2 * NN);
    localparam int TW  = (NNN > 1) ? $clog2(NNN) : 1;
    // Wide enough for N products of two WIDTH-bit values, so it never wraps.
    localparam int AW  = 2 * WIDTH + IW;

    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_CALC} state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    e_q, e_d;
    logic [TW-1:0]    t_q, t_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] a_q [N][N];
    logic [WIDTH-1:0] a_d [N][N];
    logic [WIDTH-1:0] b_q [N][N];
    logic [WIDTH-1:0] b_d [N][N];
    logic [WIDTH-1:0] res_q [N][N];
    logic [WIDTH-1:0] res_d [N][N];
    logic             done_q, done_d;
    logic             res_valid_q, res_valid_d;
    logic             ovf_q, ovf_d;

    logic [IW-1:0]    ld_row, ld_col;
    logic [IW-1:0]    mi, mj, mk;
    logic [AW-1:0]    acc_next;

    // Decode load position from e and MAC indices i/j/k from t.
    always_comb begin
        ld_row   = IW'((int'(e_q) % NN) / N);
        ld_col   = IW'(int'(e_q) % N);
        mi       = IW'(int'(t_q) / NN);
        mj       = IW'((int'(t_q) / N) % N);
        mk       = IW'(int'(t_q) % N);
        acc_next = ((mk == IW'(0)) ? '0 : acc_q)
                 + AW'(a_q[mi][mk]) * AW'(b_q[mk][mj]);
    end

    // Next-state and datapath updates for the LOAD/WAIT/CALC sequence.
    always_comb begin
        state_d     = state_q;
        e_d         = e_q;
        t_d         = t_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (int'(e_q) < NN) a_d[ld_row][ld_col] = in_data;
                    else                b_d[ld_row][ld_col] = in_data;
                    if (e_q == EW'(2 * NN - 1)) begin
                        e_d     = '0;
                        state_d = S_WAIT;
                    end else begin
                        e_d = e_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // start has priority over reload
                if (start) begin
                    state_d     = S_CALC;
                    t_d         = '0;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    res_valid_d = 1'b0;
                end else if (reload) begin
                    state_d = S_LOAD;
                    e_d     = '0;
                end
            end
            S_CALC: begin
                acc_d = acc_next;
                if (mk == IW'(N - 1)) begin
                    res_d[mi][mj] = acc_next[WIDTH-1:0];
                    if (|acc_next[AW-1:WIDTH]) ovf_d = 1'b1;
                end
                if (t_q == TW'(NNN - 1)) begin
                    t_d         = '0;
                    state_d     = S_WAIT;
                    done_d      = 1'b1;
                    res_valid_d = 1'b1;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            e_q         <= '0;
            t_q         <= '0;
            acc_q       <= '0;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            res_q       <= '{default: '0};
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            t_q         <= t_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Combinational result read; addresses outside the matrix read as zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_row) < N && int'(rd_col) < N) rd_data = res_q[rd_row][rd_col];
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_CALC);
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized bench for matmul_sequencer against a plain matrix-product model.
module tb_matmul_sequencer;

    localparam int WIDTH = 8;
    localparam int N     = 2;
    localparam int NN    = N * N;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             start;
    logic             reload;
    logic             busy;
    logic             done;
    logic             res_valid;
    logic             ovf;
    logic [0:0]       rd_row;
    logic [0:0]       rd_col;
    logic [WIDTH-1:0] rd_data;

    matmul_sequencer #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start(start), .reload(reload), .busy(busy), .done(done),
        .res_valid(res_valid), .ovf(ovf),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int ma [N][N];
    int mb [N][N];
    int mc [N][N];
    int movf;
    int mrv;
    int vals [2*NN];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0;
            end
        movf = 0;
        mrv  = 0;
    endtask

    task automatic model_product();
        movf = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
                mc[i][j] = s % 256;
                if (s > 255) movf = 1;
            end
    endtask

    task automatic check_res(input string tag);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                rd_row = 1'(r);
                rd_col = 1'(c);
                #1;
                check($sformatf("%s_c%0d%0d", tag, r, c), rd_data, mc[r][c]);
            end
        check({tag, "_ovf"}, ovf, movf);
        check({tag, "_res_valid"}, res_valid, mrv);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; start = 0; reload = 0;
        tick();
        rst = 0;
        model_clear();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_res("rst");
    endtask

    task automatic load(input bit gaps, input int start_at);
        for (int idx = 0; idx < 2*NN; idx++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    in_valid = 0;
                    in_data  = 8'($urandom);
                    tick();
                end
            end
            in_valid = 1;
            in_data  = 8'(vals[idx]);
            if (idx == start_at) start = 1;
            check("in_ready_load", in_ready, 1);
            tick();
            start = 0;
            if (idx == start_at) check("start_in_load_ignored", busy, 0);
            if (idx < NN) ma[idx / N][idx % N] = vals[idx];
            else          mb[(idx - NN) / N][(idx - NN) % N] = vals[idx];
        end
        in_valid = 0;
        check("in_ready_after_load", in_ready, 0);
    endtask

    task automatic run_calc(input bit with_reload, input bit noisy);
        int cnt;
        start  = 1;
        reload = with_reload;
        tick();
        start  = 0;
        reload = 0;
        model_product();
        mrv = 0;
        check("calc_busy_first", busy, 1);
        check("calc_ovf_cleared", ovf, 0);
        check("calc_res_valid_cleared", res_valid, 0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            check("done_while_busy", done, 0);
            cnt++;
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                start    = 1'($urandom_range(0, 1));
                reload   = 1'($urandom_range(0, 1));
            end
            tick();
        end
        in_valid = 0; start = 0; reload = 0;
        check("busy_len", cnt, N*N*N);
        check("done_pulse", done, 1);
        check("done_busy_low", busy, 0);
        mrv = 1;
        check_res("calc");
        tick();
        check("done_one_cycle", done, 0);
    endtask

    task automatic pulse_reload();
        reload = 1;
        tick();
        reload = 0;
        check("reload_in_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        rst = 1; in_valid = 0; in_data = 0; start = 0; reload = 0;
        rd_row = 0; rd_col = 0;
        repeat (2) tick();
        do_reset();

        // Known product, continuous stream
        vals = '{4, 5, 2, 6, 1, 3, 7, 2};
        load(1'b0, -1);
        run_calc(1'b0, 1'b0);

        // Repeat start without reload; noise during CALC must be ignored
        run_calc(1'b0, 1'b1);

        // start and reload together: start wins
        run_calc(1'b1, 1'b0);
        pulse_reload();
        check_res("after_reload");

        // Overflow case, gapped load with a start pulse in LOAD
        vals = '{200, 200, 0, 0, 1, 0, 1, 0};
        load(1'b1, 3);
        run_calc(1'b0, 1'b0);
        run_calc(1'b0, 1'b1);

        // Random matrices, random gaps and noise
        for (int r = 0; r < 6; r++) begin
            pulse_reload();
            for (int i = 0; i < 2*NN; i++)
                vals[i] = (r % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
            load(1'b1, -1);
            run_calc(1'b0, 1'b1);
        end

        // Gapped reload of the first matrices reproduces the first results
        pulse_reload();
        vals = '{4, 5, 2, 6, 1, 3, 7, 2};
        load(1'b1, -1);
        run_calc(1'b0, 1'b0);

        // Reset in the middle of CALC aborts without a done pulse
        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        check("abort_busy_before", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        model_clear();
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_done", done, 0);
        check_res("abort");
        seen = 0;
        repeat (12) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        check("abort_no_done", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
